// File: rtl/alu_divider8.sv
// alu_divider8: sequential 8-bit signed restoring divider, one quotient bit per clock
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, sampled only while idle
//   a, b                signed dividend / divisor (two's complement)
//   busy                high while a division is in progress
//   done                one-cycle pulse when results are valid
//   quotient, remainder signed results, truncating toward zero; held until next done
//   div_zero, OF        divisor was zero / quotient not representable (-128 / -1)
module alu_divider8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_zero,
    output logic       OF
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [7:0] q, d, abs_a, abs_b, diff;
    // Partial remainder is always below the divisor (<= 128), so 8 bits hold it;
    // the trial value t carries the extra ninth bit.
    logic [7:0] r;
    logic [8:0] t;
    logic [2:0] cnt;
    logic       neg_q, neg_r, ge;
    assign abs_a = a[7] ? -a : a;
    assign abs_b = b[7] ? -b : b;
    assign busy  = state != IDLE;
    always_comb begin
        t        = {r, q[7]};
        ge       = t >= {1'b0, d};
        diff     = t[7:0] - d;
        state_nx = (state == IDLE) ? ((start && |b) ? CALC : IDLE) :
                   (state == CALC) ? (&cnt ? FIX : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            d         <= '0;
            r         <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            OF        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (|b) begin
                        q     <= abs_a;
                        d     <= abs_b;
                        r     <= '0;
                        cnt   <= '0;
                        neg_q <= a[7] ^ b[7];
                        neg_r <= a[7];
                    end else begin
                        quotient  <= 8'hFF;
                        remainder <= a;
                        div_zero  <= 1'b1;
                        OF        <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                CALC: begin
                    r   <= ge ? diff : t[7:0];
                    q   <= {q[6:0], ge};
                    cnt <= cnt + 3'd1;
                end
                FIX: begin
                    quotient  <= neg_q ? -q : q;
                    remainder <= neg_r ? -r : r;
                    // Only -128 / -1 yields a positive magnitude of 128.
                    OF        <= (q == 8'h80) && !neg_q;
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
